// File: rtl/scan_bridge_pkg.sv
// Shared definitions for the scan-chain debug bridge: chain field layout,
// default bus widths and transaction FSM encoding.
package scan_bridge_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam int WEN_POS  = 0;
    localparam int REN_POS  = 1;
    localparam int ADDR_POS = 2;

    function automatic int wdata_pos(input int aw);
        return ADDR_POS + aw;
    endfunction

    function automatic int rdata_pos(input int aw, input int dw);
        return ADDR_POS + aw + dw;
    endfunction

    function automatic int ready_pos(input int aw, input int dw);
        return ADDR_POS + aw + 2 * dw;
    endfunction

    function automatic int chain_len(input int aw, input int dw);
        return 3 + aw + 2 * dw;
    endfunction

    localparam int CHAIN_LEN = chain_len(ADDR_W_DEF, DATA_W_DEF);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/scan_sync.sv
// Multi-flop synchronizer for one asynchronous scan input, with an extra
// history flop providing rise, fall and any-edge strobes in the clk domain.
module scan_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic any_edge
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level    = sync_q[STAGES-1];
    assign rise     = level & ~prev_q;
    assign fall     = ~level & prev_q;
    assign any_edge = level ^ prev_q;

endmodule

// File: rtl/scan_bus_bridge.sv
// Scan-chain debug responder: a tester shifts a command frame in, toggles
// scan_id to run one bus transaction, then captures the result for shift-out.
module scan_bus_bridge
    import scan_bridge_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_phi,
    input  logic              scan_phi_bar,
    input  logic              scan_data_in,
    input  logic              scan_load_chip,
    input  logic              scan_load_chain,
    input  logic              scan_id,
    output logic              scan_data_out,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int LEN     = chain_len(ADDR_W, DATA_W);
    localparam int WD_POS  = wdata_pos(ADDR_W);
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic phi_rise, phi_bar_rise, load_chip_rise, id_edge;
    logic data_level, load_chain_level;
    logic phi_level_unused, phi_fall_unused, phi_edge_unused;
    logic phib_level_unused, phib_fall_unused, phib_edge_unused;
    logic data_rise_unused, data_fall_unused, data_edge_unused;
    logic chip_level_unused, chip_fall_unused, chip_edge_unused;
    logic chain_rise_unused, chain_fall_unused, chain_edge_unused;
    logic id_level_unused, id_rise_unused, id_fall_unused;

    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_phi (
        .clk(clk), .rst_n(rst_n), .async_in(scan_phi),
        .level(phi_level_unused), .rise(phi_rise),
        .fall(phi_fall_unused), .any_edge(phi_edge_unused)
    );

    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_phi_bar (
        .clk(clk), .rst_n(rst_n), .async_in(scan_phi_bar),
        .level(phib_level_unused), .rise(phi_bar_rise),
        .fall(phib_fall_unused), .any_edge(phib_edge_unused)
    );

    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .async_in(scan_data_in),
        .level(data_level), .rise(data_rise_unused),
        .fall(data_fall_unused), .any_edge(data_edge_unused)
    );

    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_load_chip (
        .clk(clk), .rst_n(rst_n), .async_in(scan_load_chip),
        .level(chip_level_unused), .rise(load_chip_rise),
        .fall(chip_fall_unused), .any_edge(chip_edge_unused)
    );

    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_load_chain (
        .clk(clk), .rst_n(rst_n), .async_in(scan_load_chain),
        .level(load_chain_level), .rise(chain_rise_unused),
        .fall(chain_fall_unused), .any_edge(chain_edge_unused)
    );

    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_id (
        .clk(clk), .rst_n(rst_n), .async_in(scan_id),
        .level(id_level_unused), .rise(id_rise_unused),
        .fall(id_fall_unused), .any_edge(id_edge)
    );

    logic [LEN-1:0]     chain_q;
    logic               master_q;
    logic               cap_q;
    logic               cfg_wen, cfg_ren;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [DATA_W-1:0]  cfg_wdata;
    logic [DATA_W-1:0]  rdata_q;
    logic               ready_q;
    logic [TIMER_W-1:0] timer_q;
    state_t             state_q;

    // Master/slave chain: phi samples the input bit, phi_bar either shifts
    // or, when a capture was armed on phi, loads the status snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q  <= '0;
            master_q <= 1'b0;
            cap_q    <= 1'b0;
        end else if (phi_bar_rise) begin
            if (cap_q) begin
                chain_q <= {ready_q, rdata_q, cfg_wdata, cfg_addr, cfg_ren, cfg_wen};
                cap_q   <= 1'b0;
            end else begin
                chain_q <= {master_q, chain_q[LEN-1:1]};
            end
        end else if (phi_rise) begin
            master_q <= data_level;
            if (load_chain_level) begin
                cap_q <= 1'b1;
            end
        end
    end

    assign scan_data_out = chain_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_wen   <= 1'b0;
            cfg_ren   <= 1'b0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
        end else if (load_chip_rise) begin
            cfg_wen   <= chain_q[WEN_POS];
            cfg_ren   <= chain_q[REN_POS];
            cfg_addr  <= chain_q[ADDR_POS +: ADDR_W];
            cfg_wdata <= chain_q[WD_POS +: DATA_W];
        end
    end

    // Transaction FSM. bus_* are launch-time copies of cfg so that a later
    // load_chip cannot disturb a request already on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            timer_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (id_edge && (cfg_wen || cfg_ren)) begin
                        state_q   <= REQ;
                        bus_req   <= 1'b1;
                        bus_we    <= cfg_wen;
                        bus_addr  <= cfg_addr;
                        bus_wdata <= cfg_wdata;
                        ready_q   <= 1'b0;
                        timer_q   <= '0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rdata_q <= bus_rdata;
                        end
                        ready_q <= 1'b1;
                        bus_req <= 1'b0;
                        state_q <= DONE;
                    end else if (timer_q == TIMER_LAST) begin
                        bus_req <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_bus_bridge.sv
// Directed bench for scan_bus_bridge: drives scan frames, plays the bus
// responder and checks bus activity and shifted-out status frames.
module tb_scan_bus_bridge;

    localparam int PH  = 6;
    localparam int LEN = 51;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_phi = 1'b0;
    logic        scan_phi_bar = 1'b0;
    logic        scan_data_in = 1'b0;
    logic        scan_load_chip = 1'b0;
    logic        scan_load_chain = 1'b0;
    logic        scan_id = 1'b0;
    logic        scan_data_out;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_rdata = 16'h0000;

    int total = 0;
    int bad = 0;

    scan_bus_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .scan_phi(scan_phi), .scan_phi_bar(scan_phi_bar),
        .scan_data_in(scan_data_in), .scan_load_chip(scan_load_chip),
        .scan_load_chain(scan_load_chain), .scan_id(scan_id),
        .scan_data_out(scan_data_out),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [LEN-1:0] make_frame(input logic ready, input logic [15:0] rdata,
                                                  input logic [15:0] wdata, input logic [15:0] addr,
                                                  input logic ren, input logic wen);
        return {ready, rdata, wdata, addr, ren, wen};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_pair(input logic bit_val, input logic capture);
        scan_data_in = bit_val;
        scan_load_chain = capture;
        wait_clks(PH);
        scan_phi = 1'b1;
        wait_clks(PH);
        scan_phi = 1'b0;
        scan_load_chain = 1'b0;
        wait_clks(PH);
        scan_phi_bar = 1'b1;
        wait_clks(PH);
        scan_phi_bar = 1'b0;
        wait_clks(PH);
    endtask

    task automatic shift_frame(input logic [LEN-1:0] f);
        for (int i = 0; i < LEN; i++) scan_pair(f[i], 1'b0);
    endtask

    task automatic read_frame(input logic capture, output logic [LEN-1:0] f);
        f = '0;
        if (capture) scan_pair(1'b0, 1'b1);
        for (int i = 0; i < LEN; i++) begin
            @(negedge clk);
            f[i] = scan_data_out;
            scan_pair(1'b0, 1'b0);
        end
    endtask

    task automatic pulse_load_chip;
        scan_load_chip = 1'b1;
        wait_clks(PH);
        scan_load_chip = 1'b0;
        wait_clks(PH);
    endtask

    task automatic wait_req(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [LEN-1:0] got;
        wait_clks(3);
        total++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, scan_data_out} !== 35'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=0",
                     {bus_req, bus_we, bus_addr, bus_wdata, scan_data_out});
        end
        rst_n = 1'b1;
        wait_clks(4);
        read_frame(1'b0, got);
        total++;
        if (got !== '0) begin
            bad++;
            $display("[TB] FAIL reset_chain got=%h want=0", got);
        end
    endtask

    task automatic test_write;
        logic [LEN-1:0] got, exp;
        logic seen;
        shift_frame(make_frame(1'b0, 16'h0, 16'h8765, 16'h0001, 1'b0, 1'b1));
        pulse_load_chip();
        scan_id = ~scan_id;
        wait_req(seen);
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL write_req_seen got=%b want=1", seen);
        end
        total++;
        if ({bus_we, bus_addr, bus_wdata} !== {1'b1, 16'h0001, 16'h8765}) begin
            bad++;
            $display("[TB] FAIL write_bus got=%h want=%h", {bus_we, bus_addr, bus_wdata},
                     {1'b1, 16'h0001, 16'h8765});
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL write_req_held got=%b want=1", bus_req);
        end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (bus_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL write_req_drop got=%b want=0", bus_req);
        end
        wait_clks(4);
        read_frame(1'b1, got);
        exp = make_frame(1'b1, 16'h0000, 16'h8765, 16'h0001, 1'b0, 1'b1);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL write_status got=%h want=%h", got, exp);
        end
    endtask

    task automatic test_read;
        logic [LEN-1:0] got, exp;
        logic seen;
        shift_frame(make_frame(1'b0, 16'h0, 16'h0000, 16'h0007, 1'b1, 1'b0));
        pulse_load_chip();
        scan_id = ~scan_id;
        wait_req(seen);
        total++;
        if ({seen, bus_we, bus_addr} !== {1'b1, 1'b0, 16'h0007}) begin
            bad++;
            $display("[TB] FAIL read_bus got=%h want=%h", {seen, bus_we, bus_addr},
                     {1'b1, 1'b0, 16'h0007});
        end
        bus_ack = 1'b1;
        bus_rdata = 16'h1234;
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = 16'h0000;
        total++;
        if (bus_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL read_req_drop got=%b want=0", bus_req);
        end
        wait_clks(4);
        read_frame(1'b1, got);
        exp = make_frame(1'b1, 16'h1234, 16'h0000, 16'h0007, 1'b1, 1'b0);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL read_status got=%h want=%h", got, exp);
        end
    endtask

    task automatic test_echo;
        logic [LEN-1:0] pat, got;
        pat = 51'h5_5555_AAAA_5555;
        shift_frame(pat);
        read_frame(1'b0, got);
        total++;
        if (got !== pat) begin
            bad++;
            $display("[TB] FAIL echo got=%h want=%h", got, pat);
        end
    endtask

    task automatic test_back_to_back;
        logic seen;
        int extra;
        shift_frame(make_frame(1'b0, 16'h0, 16'hBEEF, 16'h0042, 1'b1, 1'b1));
        pulse_load_chip();
        scan_id = ~scan_id;
        wait_req(seen);
        total++;
        if ({seen, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, 16'h0042, 16'hBEEF}) begin
            bad++;
            $display("[TB] FAIL both_set_write got=%h want=%h", {seen, bus_we, bus_addr, bus_wdata},
                     {1'b1, 1'b1, 16'h0042, 16'hBEEF});
        end
        scan_id = ~scan_id;
        repeat (10) @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_req !== 1'b0) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("[TB] FAIL toggle_in_req_ignored got=%0d want=0", extra);
        end
    endtask

    task automatic test_no_op;
        int hits;
        shift_frame('0);
        pulse_load_chip();
        scan_id = ~scan_id;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_req !== 1'b0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("[TB] FAIL no_op_req got=%0d want=0", hits);
        end
    endtask

    task automatic test_timeout;
        logic [LEN-1:0] got, exp;
        logic seen;
        int count;
        shift_frame(make_frame(1'b0, 16'h0, 16'h0000, 16'h0099, 1'b1, 1'b0));
        pulse_load_chip();
        scan_id = ~scan_id;
        wait_req(seen);
        count = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus_req !== 1'b1) break;
            count++;
            @(negedge clk);
        end
        total++;
        if (count != 256) begin
            bad++;
            $display("[TB] FAIL timeout_len got=%0d want=256", count);
        end
        wait_clks(4);
        read_frame(1'b1, got);
        exp = make_frame(1'b0, 16'h1234, 16'h0000, 16'h0099, 1'b1, 1'b0);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL timeout_status got=%h want=%h", got, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [LEN-1:0] got;
        logic seen;
        shift_frame(make_frame(1'b0, 16'h0, 16'h5A5A, 16'h00AA, 1'b0, 1'b1));
        pulse_load_chip();
        scan_id = ~scan_id;
        wait_req(seen);
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_mid_req_seen got=%b want=1", seen);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus_req, bus_we, bus_addr, bus_wdata} !== 34'd0) begin
            bad++;
            $display("[TB] FAIL rst_mid_async got=%h want=0", {bus_req, bus_we, bus_addr, bus_wdata});
        end
        scan_id = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(5);
        read_frame(1'b1, got);
        total++;
        if ({bus_req, got} !== {1'b0, 51'd0}) begin
            bad++;
            $display("[TB] FAIL rst_mid_chain got=%h want=0", {bus_req, got});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_echo();
        test_back_to_back();
        test_no_op();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_bus_bridge.md
# scan_bus_bridge

- On-chip responder for the scan-chain debug port of the SIMD engine.
- The off-chip tester shifts a 51-bit frame (wen, ren, 16-bit addr, 16-bit wdata, 16-bit rdata, ready) over scan_phi/scan_phi_bar.
- A scan_id toggle launches one memory-mapped bus transaction.
- Read data and completion status are captured back into the chain for shift-out.

## Interface
- ADDR_W, 16, bus address width
- DATA_W, 16, bus data width
- SYNC_STAGES, 2, synchronizer depth for all scan inputs
- TIMEOUT_CYCLES, 256, max cycles waiting for bus_ack
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- scan_phi, scan_phi_bar  in  1 each  non-overlapping scan shift phases, asynchronous to clk
- scan_data_in  in  1  serial data in
- scan_load_chip  in  1  pulse: commit chain fields to config registers
- scan_load_chain  in  1  level: capture status into chain on the next phi/phi_bar pair
- scan_id  in  1  toggle: launch a transaction
- scan_data_out  out  1  chain bit 0
- bus_req  out  1  request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  transaction address
- bus_wdata  out  DATA_W  write data
- bus_ack  in  1  single-cycle completion
- bus_rdata  in  DATA_W  read data, valid with bus_ack

## Operation
- Frame layout, LSB first:
  - [0] wen
  - [1] ren
  - [17:2] addr
  - [33:18] wdata
  - [49:34] rdata
  - [50] ready
- CHAIN_LEN = 3 + ADDR_W + 2·DATA_W.
- All six scan inputs pass through SYNC_STAGES flops plus an edge-detect flop. All actions key off synced edges.
- scan_phi rise: master_q <= synced scan_data_in. If synced scan_load_chain is high, set cap_q.
- scan_phi_bar rise:
  - cap_q = 0: shift, chain_q <= {master_q, chain_q[CHAIN_LEN-1:1]}.
  - cap_q = 1: parallel load chain_q <= {ready_q, rdata_q, cfg_wdata, cfg_addr, cfg_ren, cfg_wen}, then clear cap_q.
- scan_data_out = chain_q[0], registered.
- scan_load_chip rise: cfg_wen/ren/addr/wdata <= chain_q fields. Chain rdata/ready fields are ignored.
- scan_id edge, either polarity, with FSM in IDLE:
  - cfg_wen = 1: launch a write. Write wins if ren is also set.
  - Else cfg_ren = 1: launch a read.
  - Else: no action.
- On launch: copy cfg into the bus_* output registers and clear ready_q.
- FSM states IDLE, REQ, DONE:
  - IDLE -> REQ on launch.
  - REQ: bus_req = 1 with stable bus_we/addr/wdata.
  - REQ -> DONE on bus_ack. A read also captures rdata_q <= bus_rdata. ready_q <= 1.
  - REQ -> DONE when the timer reaches TIMEOUT_CYCLES-1 with no ack. bus_req drops, ready_q stays 0, rdata_q unchanged.
  - DONE -> IDLE unconditionally after 1 cycle.
- scan_id edge outside IDLE: ignored, not queued.
- load_chip during REQ: cfg updates, but the in-flight bus_* values are unaffected (they are launch copies).

## Timing
- Reset values: all outputs 0, FSM IDLE; chain_q, master_q, cfg_*, rdata_q, ready_q, cap_q, timer all 0.
- Reset asserted mid-transaction drops bus_req immediately and discards the transaction.
- Scan-input to action latency: SYNC_STAGES+1 clk cycles.
- Each scan pulse high and low phase must last ≥ SYNC_STAGES+2 clk cycles; shorter pulses are undefined.
- bus_req is asserted the cycle after the synced scan_id edge.
- bus_ack is sampled only while bus_req = 1; ack in the cycle req rises is accepted.
- ready_q and rdata_q are visible to a load_chain capture from the cycle after DONE.
- A capture taken during REQ returns ready = 0 and the old rdata.

## Structure
- Package scan_bridge_pkg holds:
  - field offset/width localparams
  - CHAIN_LEN
  - typedef enum state_t {IDLE, REQ, DONE}
- Sub-module scan_sync: SYNC_STAGES-flop synchronizer plus rise/fall/any-edge outputs, async active-low reset. Instantiated once per scan input.

## Test plan
- Write 0x0001/0x8765: rotate frame, load_chip, toggle scan_id -> one bus_req with we=1, addr=0x0001, wdata=0x8765. Ack after 3 cycles -> bus_req low the next cycle, ready_q = 1.
- Read 0x0007, responder returns 0x1234: load_chain + rotate -> shifted-out bits [49:34] = 0x1234, [50] = 1, [17:2] = 0x0007, [1] = 1.
- Echo: rotate 51-bit pattern 0x5_5555_AAAA_5555, then rotate zeros -> the first pattern comes out unchanged, bit 0 first.
- wen = ren = 1, toggle -> a single write. Toggle with both 0 -> no bus_req. Second toggle during REQ -> ignored, exactly one ack consumed.
- No ack -> bus_req held exactly TIMEOUT_CYCLES cycles, then low. Captured ready = 0, rdata unchanged.
- rst_n low during REQ -> bus_req = 0 asynchronously. After release, chain shifts out all zeros.
